// File: rtl/mem_pkg.sv
// Shared types for the data memory arbiter: FSM states, access size codes
// and transaction owner encoding.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    FIN,
    RESP
  } state_e;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester ports A/B plus the byte-wide memory command bus. The arbiter
// connects through the slave modport; the environment uses master.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 16
) ();

  logic              a_req;
  logic              a_wr;
  logic              a_size;
  logic              a_sext;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_wdata;
  logic              a_done;
  logic [15:0]       a_rdata;

  logic              b_req;
  logic              b_wr;
  logic              b_size;
  logic              b_sext;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_wdata;
  logic              b_done;
  logic [15:0]       b_rdata;

  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport slave (
    input  a_req, a_wr, a_size, a_sext, a_addr, a_wdata,
    input  b_req, b_wr, b_size, b_sext, b_addr, b_wdata,
    input  mem_rdata,
    output a_done, a_rdata, b_done, b_rdata, busy,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output a_req, a_wr, a_size, a_sext, a_addr, a_wdata,
    output b_req, b_wr, b_size, b_sext, b_addr, b_wdata,
    output mem_rdata,
    input  a_done, a_rdata, b_done, b_rdata, busy,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for a byte-wide single-port data memory: A has priority,
// B is protected from starvation, 16-bit accesses split into two byte beats.
module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              wr_q, wr_d;
  logic              size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       a_rdata_q, a_rdata_d;
  logic [15:0]       b_rdata_q, b_rdata_d;
  logic [3:0]        starve_q, starve_d;

  logic              grant_a;
  logic              grant_b;
  logic              beat;
  logic [15:0]       load_result;

  always_comb begin
    // NOTE: every _d holds its register value first, so no branch below can infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    size_d    = size_q;
    sext_d    = sext_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    starve_d  = starve_q;

    grant_a = bus.a_req && (starve_q < LIMIT);
    grant_b = !grant_a && bus.b_req;

    // In FIN, mem_rdata carries the last byte of the access.
    load_result = (size_q == SZ_WORD) ? {bus.mem_rdata, lo_q}
                                      : {{8{sext_q & bus.mem_rdata[7]}}, bus.mem_rdata};

    unique case (state_q)
      IDLE: begin
        // A can only win below the limit, so the count never passes it.
        starve_d = (grant_a && bus.b_req) ? starve_q + 4'd1 : 4'd0;
        if (grant_a) begin
          owner_d = OWN_A;
          wr_d    = bus.a_wr;
          size_d  = bus.a_size;
          sext_d  = bus.a_sext;
          addr_d  = bus.a_addr;
          wdata_d = bus.a_wdata;
          state_d = BEAT0;
        end else if (grant_b) begin
          owner_d = OWN_B;
          wr_d    = bus.b_wr;
          size_d  = bus.b_size;
          sext_d  = bus.b_sext;
          addr_d  = bus.b_addr;
          wdata_d = bus.b_wdata;
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        if (size_q == SZ_WORD) state_d = BEAT1;
        else if (wr_q)         state_d = RESP;
        else                   state_d = FIN;
      end
      BEAT1: begin
        if (!wr_q) lo_d = bus.mem_rdata;
        state_d = wr_q ? RESP : FIN;
      end
      FIN: begin
        if (owner_q == OWN_A) a_rdata_d = load_result;
        else                  b_rdata_d = load_result;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory command is a pure decode of state and latched fields.
  always_comb begin
    beat          = (state_q == BEAT0) || (state_q == BEAT1);
    bus.mem_re    = beat && !wr_q;
    bus.mem_we    = beat && wr_q;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == BEAT0) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wr_q ? wdata_q[7:0] : 8'h00;
    end else if (state_q == BEAT1) begin
      bus.mem_addr  = addr_q + ADDR_W'(1);
      bus.mem_wdata = wr_q ? wdata_q[15:8] : 8'h00;
    end
    bus.busy    = (state_q != IDLE);
    bus.a_done  = (state_q == RESP) && (owner_q == OWN_A);
    bus.b_done  = (state_q == RESP) && (owner_q == OWN_B);
    bus.a_rdata = a_rdata_q;
    bus.b_rdata = b_rdata_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each flop samples pre-edge values of the others.
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_A;
      wr_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      sext_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: a byte memory macro model plus a transaction-level
// reference (byte array, latency table, starvation rule) for randomized traffic.
module tb_data_mem_arbiter;

  localparam int ADDR_W       = 16;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic        wr;
    logic        size;
    logic        sext;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] exp_a_rdata;
  logic [15:0] exp_b_rdata;
  int          sc_model;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 8) ^ 8'h5A);
  endfunction

  // Memory macro: registered read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input txn_t t);
    return (t.size ? 2 : 1) + (t.wr ? 1 : 2);
  endfunction

  function automatic logic [15:0] model_load(input txn_t t);
    logic [15:0] a1;
    logic [7:0]  b0;
    a1 = t.addr + 16'd1;
    b0 = ref_mem[t.addr];
    if (t.size) return {ref_mem[a1], b0};
    return {{8{t.sext & b0[7]}}, b0};
  endfunction

  task automatic model_store(input txn_t t);
    logic [15:0] a1;
    a1 = t.addr + 16'd1;
    ref_mem[t.addr] = t.wdata[7:0];
    if (t.size) ref_mem[a1] = t.wdata[15:8];
  endtask

  // Arbitration rule: A wins unless B has already lost STARVE_LIMIT times in a row.
  task automatic decide(input bit ra, input bit rb, output bit a_wins);
    a_wins = ra && (sc_model < STARVE_LIMIT);
    if (!rb || !a_wins) sc_model = 0;
    else sc_model = (sc_model + 1 > STARVE_LIMIT) ? STARVE_LIMIT : sc_model + 1;
  endtask

  task automatic drive(input bit is_a, input txn_t t);
    if (is_a) begin
      bus.a_wr = t.wr; bus.a_size = t.size; bus.a_sext = t.sext;
      bus.a_addr = t.addr; bus.a_wdata = t.wdata;
    end else begin
      bus.b_wr = t.wr; bus.b_size = t.size; bus.b_sext = t.sext;
      bus.b_addr = t.addr; bus.b_wdata = t.wdata;
    end
  endtask

  task automatic jumble(input bit is_a);
    if (is_a) begin
      bus.a_addr = 16'($urandom); bus.a_wdata = 16'($urandom);
    end else begin
      bus.b_addr = 16'($urandom); bus.b_wdata = 16'($urandom);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr    = 1'($urandom_range(0, 1));
    t.size  = 1'($urandom_range(0, 1));
    t.sext  = 1'($urandom_range(0, 1));
    t.wdata = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       t.addr = 16'hFFFF;
      1:       t.addr = 16'($urandom_range(0, 7));
      default: t.addr = 16'($urandom);
    endcase
    return t;
  endfunction

  // Expected memory command in local cycle c after the grant edge.
  task automatic check_cmd(input string tag, input txn_t t, input int c);
    logic       beat;
    logic [15:0] ea;
    beat = (c == 1) || (c == 2 && t.size);
    check({tag, "_busy"}, bus.busy, 1'b1);
    check({tag, "_re"}, bus.mem_re, beat && !t.wr);
    check({tag, "_we"}, bus.mem_we, beat && t.wr);
    if (beat) begin
      ea = (c == 1) ? t.addr : t.addr + 16'd1;
      check({tag, "_addr"}, bus.mem_addr, ea);
      if (t.wr) check({tag, "_wdata"}, bus.mem_wdata, (c == 1) ? t.wdata[7:0] : t.wdata[15:8]);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_re"}, bus.mem_re, 1'b0);
    check({tag, "_we"}, bus.mem_we, 1'b0);
    check({tag, "_a_done"}, bus.a_done, 1'b0);
    check({tag, "_b_done"}, bus.b_done, 1'b0);
  endtask

  task automatic finish_txn(input string tag, input bit is_a, input txn_t t);
    if (!t.wr) begin
      if (is_a) exp_a_rdata = model_load(t);
      else      exp_b_rdata = model_load(t);
    end else begin
      model_store(t);
    end
    check({tag, "_a_rdata"}, bus.a_rdata, exp_a_rdata);
    check({tag, "_b_rdata"}, bus.b_rdata, exp_b_rdata);
    if (is_a) bus.a_req = 1'b0;
    else      bus.b_req = 1'b0;
  endtask

  // One or two simultaneous requests, checked cycle by cycle until both complete.
  task automatic run_txn(input string tag, input bit use_a, input bit use_b,
                         input txn_t ta, input txn_t tb_in, input bit scramble);
    bit   a_first, unused, both;
    txn_t tw, tl;
    int   lw, ll, total;
    both = use_a && use_b;
    decide(use_a, use_b, a_first);
    if (both) decide(!a_first, a_first, unused);
    tw    = a_first ? ta : tb_in;
    tl    = a_first ? tb_in : ta;
    lw    = lat(tw);
    ll    = both ? lat(tl) : 0;
    total = both ? lw + 1 + ll : lw;
    @(negedge clk);
    if (use_a) begin drive(1'b1, ta);    bus.a_req = 1'b1; end
    if (use_b) begin drive(1'b0, tb_in); bus.b_req = 1'b1; end
    for (int t = 1; t <= total; t++) begin
      @(negedge clk);
      check({tag, "_a_done"}, bus.a_done, (t == lw && a_first) || (both && t == total && !a_first));
      check({tag, "_b_done"}, bus.b_done, (t == lw && !a_first) || (both && t == total && a_first));
      if (t <= lw)          check_cmd(tag, tw, t);
      else if (t == lw + 1) check_idle({tag, "_gap"});
      else                  check_cmd(tag, tl, t - lw - 1);
      if (t == lw) finish_txn(tag, a_first, tw);
      if (both && t == total) finish_txn(tag, !a_first, tl);
      if (scramble) begin
        if (t < lw) jumble(a_first);
        else if (both && t > lw + 1 && t < total) jumble(!a_first);
      end
    end
    @(negedge clk);
    check_idle({tag, "_after"});
  endtask

  task automatic contention_test();
    txn_t ta, tbx, tcur;
    bit   order [10];
    int   k, c;
    ta.wr = 1'b1;  ta.size = 1'b0;  ta.sext = 1'b0;  ta.addr = 16'h0100;  ta.wdata = 16'($urandom);
    tbx.wr = 1'b1; tbx.size = 1'b0; tbx.sext = 1'b0; tbx.addr = 16'h0200; tbx.wdata = 16'($urandom);
    for (int i = 0; i < 10; i++) decide(1'b1, 1'b1, order[i]);
    @(negedge clk);
    drive(1'b1, ta);  bus.a_req = 1'b1;
    drive(1'b0, tbx); bus.b_req = 1'b1;
    for (int t = 1; t <= 29; t++) begin
      @(negedge clk);
      k = (t - 1) / 3;
      c = (t - 1) % 3 + 1;
      tcur = order[k] ? ta : tbx;
      if (c == 3) begin
        check_idle("cont_gap");
      end else begin
        check_cmd("cont", tcur, c);
        check("cont_a_done", bus.a_done, c == 2 && order[k]);
        check("cont_b_done", bus.b_done, c == 2 && !order[k]);
        if (c == 2) begin
          model_store(tcur);
          check("cont_a_rdata", bus.a_rdata, exp_a_rdata);
          check("cont_b_rdata", bus.b_rdata, exp_b_rdata);
          if (k == 9) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
        end
      end
    end
    @(negedge clk);
    check_idle("cont_after");
  endtask

  task automatic held_test();
    txn_t t;
    t.wr = 1'b0; t.size = 1'b1; t.sext = 1'b0; t.addr = 16'h0040; t.wdata = 16'h0000;
    @(negedge clk);
    drive(1'b1, t);
    bus.a_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("held_a_done", bus.a_done, i == 4 || i == 9);
      check("held_b_done", bus.b_done, 1'b0);
      check("held_b_rdata", bus.b_rdata, exp_b_rdata);
      if (i <= 4)      check_cmd("held1", t, i);
      else if (i == 5) check_idle("held_gap");
      else             check_cmd("held2", t, i - 5);
      if (i == 4) begin
        exp_a_rdata = model_load(t);
        check("held1_a_rdata", bus.a_rdata, exp_a_rdata);
      end
      if (i == 9) finish_txn("held2", 1'b1, t);
    end
    @(negedge clk);
    check_idle("held_after");
  endtask

  task automatic reset_test();
    txn_t t;
    t.wr = 1'b0; t.size = 1'b1; t.sext = 1'b0; t.addr = 16'h0300; t.wdata = 16'h0000;
    @(negedge clk);
    drive(1'b1, t);
    bus.a_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst");
    check("rst_a_rdata", bus.a_rdata, 16'h0000);
    check("rst_b_rdata", bus.b_rdata, 16'h0000);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    reset = 1'b0;
    bus.a_req = 1'b0;
    exp_a_rdata = 16'h0000;
    exp_b_rdata = 16'h0000;
    sc_model = 0;
    repeat (3) begin
      @(negedge clk);
      check_idle("rst_quiet");
    end
    run_txn("rst_next", 1'b1, 1'b0, t, t, 1'b0);
  endtask

  initial begin
    txn_t t, u;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    reset = 1'b1;
    preload = 1'b1;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    drive(1'b1, '0);
    drive(1'b0, '0);
    exp_a_rdata = 16'h0000;
    exp_b_rdata = 16'h0000;
    sc_model = 0;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_a_rdata", bus.a_rdata, 16'h0000);
    check("reset_b_rdata", bus.b_rdata, 16'h0000);
    check("reset_mem_addr", bus.mem_addr, 16'h0000);
    check("reset_mem_wdata", bus.mem_wdata, 8'h00);
    reset = 1'b0;

    // B plants 0x9C at 0x0010, then A loads it with and without sign extension.
    t.wr = 1'b1; t.size = 1'b0; t.sext = 1'b0; t.addr = 16'h0010; t.wdata = 16'h559C;
    run_txn("b_st10", 1'b0, 1'b1, t, t, 1'b0);
    t.wr = 1'b0; t.sext = 1'b1;
    run_txn("ld_sext1", 1'b1, 1'b0, t, t, 1'b0);
    t.sext = 1'b0;
    run_txn("ld_sext0", 1'b1, 1'b0, t, t, 1'b0);

    // Word store across the top of the address space, then read it back.
    t.wr = 1'b1; t.size = 1'b1; t.sext = 1'b0; t.addr = 16'hFFFF; t.wdata = 16'hBEEF;
    run_txn("wrap_st", 1'b1, 1'b0, t, t, 1'b0);
    t.wr = 1'b0;
    run_txn("wrap_ld", 1'b1, 1'b0, t, t, 1'b0);

    contention_test();
    held_test();

    for (int n = 0; n < 200; n++) begin
      t = rand_txn();
      u = rand_txn();
      case ($urandom_range(0, 2))
        0:       run_txn("rnd_a", 1'b1, 1'b0, t, u, 1'b1);
        1:       run_txn("rnd_b", 1'b0, 1'b1, t, u, 1'b1);
        default: run_txn("rnd_ab", 1'b1, 1'b1, t, u, 1'b1);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    reset_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
